// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus blocks.
//   cmd_e          : {cs_n,ras_n,cas_n,we_n} encodings with cs_n low
//   init_state_e   : device initialisation FSM states
//   DEF_*          : default timing constants, in sys_clk cycles
//   ERR_*          : bit positions inside err_flags
//   sdram_decode() : pin vector to command, DESELECT folded into NOP
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_LMR  = 4'b0000,
    CMD_AREF = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_BST  = 4'b0110,
    CMD_NOP  = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    S_WAIT_PRE  = 2'd0,
    S_WAIT_AREF = 2'd1,
    S_WAIT_MRS  = 2'd2,
    S_READY     = 2'd3
  } init_state_e;

  localparam int DEF_T_RP      = 2;
  localparam int DEF_T_RFC     = 7;
  localparam int DEF_T_MRD     = 3;
  localparam int DEF_T_RCD     = 2;
  localparam int DEF_INIT_AREF = 8;
  localparam int DEF_REF_MAX   = 750;
  localparam int NUM_BANKS     = 4;

  localparam int ERR_TIMING   = 0;
  localparam int ERR_INIT     = 1;
  localparam int ERR_REF      = 2;
  localparam int ERR_ACT_OPEN = 3;
  localparam int ERR_RW_CLOSE = 4;
  localparam int ERR_RCD      = 5;
  localparam int NUM_ERR      = 6;

  // cs_n high deselects the device, which behaves exactly like NOP.
  function automatic cmd_e sdram_decode(input logic [3:0] pins);
    if (pins[3]) return CMD_NOP;
    return cmd_e'(pins);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank's state: row-open bit and ACTIVE-to-READ/WRITE (tRCD) counter.
//   clk, rst          : sys_clk, synchronous active-high reset
//   act_i             : ACTIVE to this bank
//   pre_i             : PRECHARGE covering this bank (single or all)
//   rw_i, ap_i        : READ/WRITE to this bank, with auto-precharge
//   open_o            : registered row-open bit
//   err_*_o           : combinational violations for the current command
module sdram_bank_tracker
  import sdram_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD
) (
  input  logic clk,
  input  logic rst,
  input  logic act_i,
  input  logic pre_i,
  input  logic rw_i,
  input  logic ap_i,
  output logic open_o,
  output logic err_act_open_o,
  output logic err_rw_closed_o,
  output logic err_rcd_o
);

  // The counter holds T_RCD-1 after the ACTIVE edge, so a READ/WRITE
  // exactly T_RCD cycles later sees zero and is legal.
  localparam int              RCD_W    = (T_RCD > 1) ? $clog2(T_RCD) : 1;
  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'((T_RCD > 0) ? T_RCD - 1 : 0);

  logic             open_q, open_d;
  logic [RCD_W-1:0] rcd_q, rcd_d;

  always_comb begin
    open_d = open_q;
    rcd_d  = (rcd_q != '0) ? rcd_q - RCD_W'(1) : rcd_q;
    if (act_i) begin
      open_d = 1'b1;
      rcd_d  = RCD_LOAD;
    end
    if (pre_i)         open_d = 1'b0;
    if (rw_i && ap_i)  open_d = 1'b0;
  end

  assign err_act_open_o  = act_i & open_q;
  assign err_rw_closed_o = rw_i & ~open_q;
  assign err_rcd_o       = rw_i & (rcd_q != '0);
  assign open_o          = open_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= 1'b0;
      rcd_q  <= '0;
    end else begin
      open_q <= open_d;
      rcd_q  <= rcd_d;
    end
  end

endmodule

// File: rtl/sdram_cmd_monitor.sv
// Passive protocol checker for an SDRAM command bus.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   sdram_cmd        : {cs_n,ras_n,cas_n,we_n}
//   sdram_ba         : bank address
//   sdram_addr       : address bus (bit 10 = all-banks / auto-precharge)
//   init_done        : init sequence PRE-all, INIT_AREF x AREF, LMR accepted
//   mode_reg         : last LOAD_MODE address value
//   bank_open        : per-bank row-open bits
//   aref_cnt         : AUTO_REFRESH count since reset, saturating
//   err_flags        : sticky error bits (see ERR_* in sdram_pkg)
//   err_pulse        : one-cycle strobe when any err_flags bit newly sets
// Every output is a flop, so each reflects the command of the previous edge.
module sdram_cmd_monitor
  import sdram_pkg::*;
#(
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RFC     = DEF_T_RFC,
  parameter int T_MRD     = DEF_T_MRD,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int INIT_AREF = DEF_INIT_AREF,
  parameter int REF_MAX   = DEF_REF_MAX
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [3:0]           sdram_cmd,
  input  logic [1:0]           sdram_ba,
  input  logic [12:0]          sdram_addr,
  output logic                 init_done,
  output logic [12:0]          mode_reg,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [15:0]          aref_cnt,
  output logic [NUM_ERR-1:0]   err_flags,
  output logic                 err_pulse
);

  // Gap counter holds guard-1 after the command edge: the next non-NOP
  // is legal exactly guard cycles after the guarded command.
  localparam int GAP_MAX = max3(T_RP, T_RFC, T_MRD);
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam logic [GAP_W-1:0] G_RP  = GAP_W'((T_RP  > 0) ? T_RP  - 1 : 0);
  localparam logic [GAP_W-1:0] G_RFC = GAP_W'((T_RFC > 0) ? T_RFC - 1 : 0);
  localparam logic [GAP_W-1:0] G_MRD = GAP_W'((T_MRD > 0) ? T_MRD - 1 : 0);

  localparam int REF_W  = $clog2(REF_MAX + 1);
  localparam logic [REF_W-1:0] REF_TOP  = REF_W'(REF_MAX);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_MAX - 1);

  localparam int INIT_W = (INIT_AREF > 1) ? $clog2(INIT_AREF) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_AREF - 1);

  cmd_e cmd;
  logic is_nop, is_rw;

  init_state_e        state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [12:0]        mode_q, mode_d;
  logic [15:0]        aref_q, aref_d;
  logic [NUM_ERR-1:0] err_flags_q, err_flags_d, new_err;
  logic               err_pulse_q, err_pulse_d;
  logic               init_done_q, init_done_d;

  logic [NUM_BANKS-1:0] bank_act, bank_pre, bank_rw;
  logic [NUM_BANKS-1:0] bank_open_w, e_act_open, e_rw_closed, e_rcd;

  assign cmd    = sdram_decode(sdram_cmd);
  assign is_nop = (cmd == CMD_NOP);
  assign is_rw  = (cmd == CMD_RD) || (cmd == CMD_WR);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel         = (sdram_ba == 2'(b));
    assign bank_act[b] = (cmd == CMD_ACT) && sel;
    assign bank_pre[b] = (cmd == CMD_PRE) && (sel || sdram_addr[10]);
    assign bank_rw[b]  = is_rw && sel;

    sdram_bank_tracker #(.T_RCD(T_RCD)) u_bank (
      .clk             (sys_clk),
      .rst             (sys_rst),
      .act_i           (bank_act[b]),
      .pre_i           (bank_pre[b]),
      .rw_i            (bank_rw[b]),
      .ap_i            (sdram_addr[10]),
      .open_o          (bank_open_w[b]),
      .err_act_open_o  (e_act_open[b]),
      .err_rw_closed_o (e_rw_closed[b]),
      .err_rcd_o       (e_rcd[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
    ref_d      = ref_q;
    mode_d     = mode_q;
    aref_d     = aref_q;
    new_err    = '0;

    // Timing guard: any non-NOP reloads, violating commands still count.
    if (!is_nop) begin
      if (gap_q != '0) new_err[ERR_TIMING] = 1'b1;
      case (cmd)
        CMD_PRE:  gap_d = G_RP;
        CMD_AREF: gap_d = G_RFC;
        CMD_LMR:  gap_d = G_MRD;
        default:  gap_d = '0;
      endcase
    end

    if (cmd == CMD_AREF) begin
      aref_d = (aref_q == 16'hFFFF) ? aref_q : aref_q + 16'd1;
      if (|bank_open_w) new_err[ERR_TIMING] = 1'b1;
    end
    if (cmd == CMD_LMR) mode_d = sdram_addr;

    case (state_q)
      S_WAIT_PRE: begin
        if (cmd == CMD_PRE && sdram_addr[10]) state_d = S_WAIT_AREF;
        else if (!is_nop)                     new_err[ERR_INIT] = 1'b1;
      end
      S_WAIT_AREF: begin
        if (cmd == CMD_AREF) begin
          if (init_cnt_q == INIT_LAST) begin
            state_d    = S_WAIT_MRS;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
          end
        end else if (!is_nop) begin
          new_err[ERR_INIT] = 1'b1;
        end
      end
      S_WAIT_MRS: begin
        if (cmd == CMD_LMR) state_d = S_READY;
        else if (!is_nop)   new_err[ERR_INIT] = 1'b1;
      end
      default: begin
        // Refresh interval: parks at REF_MAX so the overdue error fires once.
        if (cmd == CMD_AREF) begin
          ref_d = '0;
        end else if (ref_q != REF_TOP) begin
          ref_d = ref_q + REF_W'(1);
          if (ref_q == REF_LAST) new_err[ERR_REF] = 1'b1;
        end
      end
    endcase

    new_err[ERR_ACT_OPEN] = |e_act_open;
    new_err[ERR_RW_CLOSE] = |e_rw_closed;
    new_err[ERR_RCD]      = |e_rcd;

    err_flags_d = err_flags_q | new_err;
    err_pulse_d = |(new_err & ~err_flags_q);
    init_done_d = (state_d == S_READY);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_WAIT_PRE;
      init_cnt_q  <= '0;
      gap_q       <= '0;
      ref_q       <= '0;
      mode_q      <= '0;
      aref_q      <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      gap_q       <= gap_d;
      ref_q       <= ref_d;
      mode_q      <= mode_d;
      aref_q      <= aref_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
  assign mode_reg  = mode_q;
  assign bank_open = bank_open_w;
  assign aref_cnt  = aref_q;
  assign err_flags = err_flags_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: hand-computed vector table, directed
// multi-cycle sequences, and random traffic against a timestamp-based model.
module tb_sdram_cmd_monitor;

  localparam int T_RP = 2, T_RFC = 7, T_MRD = 3, T_RCD = 2;
  localparam int INIT_AREF = 8, REF_MAX = 750;

  localparam logic [3:0] LMR = 4'b0000, AREF = 4'b0001, PRE = 4'b0010,
                         ACT = 4'b0011, WR = 4'b0100, RD = 4'b0101,
                         BST = 4'b0110, NOP = 4'b0111;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  sdram_cmd = NOP;
  logic [1:0]  sdram_ba = '0;
  logic [12:0] sdram_addr = '0;
  logic        init_done;
  logic [12:0] mode_reg;
  logic [3:0]  bank_open;
  logic [15:0] aref_cnt;
  logic [5:0]  err_flags;
  logic        err_pulse;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_cmd_monitor #(
    .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_RCD(T_RCD),
    .INIT_AREF(INIT_AREF), .REF_MAX(REF_MAX)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_cmd(sdram_cmd),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .init_done(init_done),
    .mode_reg(mode_reg), .bank_open(bank_open), .aref_cnt(aref_cnt),
    .err_flags(err_flags), .err_pulse(err_pulse)
  );

  // ---------------- reference model (event timestamps) ----------------
  int         m_cyc = 0;
  int         m_last_cmd, m_last_guard;
  int         m_act[4];
  bit [3:0]   m_open;
  int         m_phase, m_init_arefs, m_last_ref;
  bit [5:0]   m_flags;
  bit         m_pulse;
  int         m_aref;
  logic [12:0] m_mode;

  task automatic model(input logic r, input logic [3:0] c,
                       input logic [1:0] b, input logic [12:0] a);
    bit [5:0] ne;
    bit       nonnop;
    m_cyc++;
    if (r) begin
      m_last_cmd = -100000; m_last_guard = 0;
      for (int i = 0; i < 4; i++) m_act[i] = -100000;
      m_open = '0; m_phase = 0; m_init_arefs = 0; m_last_ref = 0;
      m_flags = '0; m_pulse = 0; m_aref = 0; m_mode = '0;
      return;
    end
    ne = '0;
    nonnop = (c[3] == 1'b0) && (c != NOP);
    if (nonnop) begin
      if (m_cyc - m_last_cmd < m_last_guard) ne[0] = 1;
      m_last_cmd   = m_cyc;
      m_last_guard = (c == PRE) ? T_RP : (c == AREF) ? T_RFC :
                     (c == LMR) ? T_MRD : 0;
    end
    if (nonnop && c == AREF && m_open != 0) ne[0] = 1;
    case (m_phase)
      0: if (nonnop && c == PRE && a[10]) m_phase = 1; else if (nonnop) ne[1] = 1;
      1: if (nonnop && c == AREF) begin
           m_init_arefs++;
           if (m_init_arefs == INIT_AREF) m_phase = 2;
         end else if (nonnop) ne[1] = 1;
      2: if (nonnop && c == LMR) begin m_phase = 3; m_last_ref = m_cyc; end
         else if (nonnop) ne[1] = 1;
      default:
         if (nonnop && c == AREF) m_last_ref = m_cyc;
         else if (m_cyc - m_last_ref == REF_MAX) ne[2] = 1;
    endcase
    if (nonnop) begin
      if (c == ACT) begin
        if (m_open[b]) ne[3] = 1;
        m_open[b] = 1; m_act[b] = m_cyc;
      end
      if (c == PRE) begin
        if (a[10]) m_open = '0; else m_open[b] = 0;
      end
      if (c == RD || c == WR) begin
        if (!m_open[b]) ne[4] = 1;
        if (m_cyc - m_act[b] < T_RCD) ne[5] = 1;
        if (a[10]) m_open[b] = 0;
      end
      if (c == AREF && m_aref < 65535) m_aref++;
      if (c == LMR) m_mode = a;
    end
    m_pulse = |(ne & ~m_flags);
    m_flags = m_flags | ne;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // One command per cycle: drive at negedge, model, sample 1ns after posedge.
  task automatic step(input logic r, input logic [3:0] c,
                      input logic [1:0] b, input logic [12:0] a);
    @(negedge sys_clk);
    sys_rst = r; sdram_cmd = c; sdram_ba = b; sdram_addr = a;
    model(r, c, b, a);
    @(posedge sys_clk);
    #1;
    chk("m_init_done", 32'(init_done), 32'(m_phase == 3));
    chk("m_bank_open", 32'(bank_open), 32'(m_open));
    chk("m_err_flags", 32'(err_flags), 32'(m_flags));
    chk("m_err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("m_aref_cnt",  32'(aref_cnt),  32'(m_aref));
    chk("m_mode_reg",  32'(mode_reg),  32'(m_mode));
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset();
    step(1'b1, NOP, 2'd0, 13'd0);
  endtask

  task automatic init_seq(input logic [12:0] mode);
    step(1'b0, PRE, 2'd0, 13'h400);
    nop(7);
    for (int i = 0; i < INIT_AREF; i++) begin
      step(1'b0, AREF, 2'd0, 13'd0);
      nop(7);
    end
    step(1'b0, LMR, 2'd0, mode);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_mode", 32'(mode_reg), 32'(mode));
    chk("init_flags", 32'(err_flags), 32'd0);
    chk("init_arefs", 32'(aref_cnt), 32'(INIT_AREF));
  endtask

  task automatic rand_step();
    logic [3:0]  c;
    logic [12:0] a;
    logic        r;
    int          p;
    p = $urandom_range(0, 99);
    if (p < 50)      c = NOP;
    else if (p < 58) c = 4'b1000 | 4'($urandom_range(0, 7));
    else             c = 4'($urandom_range(0, 6));
    a = 13'($urandom);
    a[10] = 1'($urandom_range(0, 1));
    r = ($urandom_range(0, 199) == 0);
    step(r, c, 2'($urandom_range(0, 3)), a);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        done;
    logic [3:0]  open;
    logic [5:0]  flags;
    logic        pulse;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, NOP,  2'd0, 13'h000, 1'b0, 4'b0000, 6'b000000, 1'b0};
    tbl[1]  = '{1'b0, NOP,  2'd0, 13'h000, 1'b0, 4'b0000, 6'b000000, 1'b0};
    tbl[2]  = '{1'b0, ACT,  2'd1, 13'h000, 1'b0, 4'b0010, 6'b000010, 1'b1};
    tbl[3]  = '{1'b0, NOP,  2'd0, 13'h000, 1'b0, 4'b0010, 6'b000010, 1'b0};
    tbl[4]  = '{1'b0, PRE,  2'd0, 13'h400, 1'b0, 4'b0000, 6'b000010, 1'b0};
    tbl[5]  = '{1'b0, AREF, 2'd0, 13'h000, 1'b0, 4'b0000, 6'b000011, 1'b1};
    tbl[6]  = '{1'b0, BST,  2'd0, 13'h000, 1'b0, 4'b0000, 6'b000011, 1'b0};
    tbl[7]  = '{1'b1, RD,   2'd0, 13'h000, 1'b0, 4'b0000, 6'b000000, 1'b0};
    tbl[8]  = '{1'b0, RD,   2'd0, 13'h000, 1'b0, 4'b0000, 6'b010010, 1'b1};
    tbl[9]  = '{1'b0, WR,   2'd2, 13'h000, 1'b0, 4'b0000, 6'b010010, 1'b0};
    tbl[10] = '{1'b1, NOP,  2'd0, 13'h000, 1'b0, 4'b0000, 6'b000000, 1'b0};

    // Reset state
    do_reset();
    do_reset();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_bank_open", 32'(bank_open), 32'd0);
    chk("rst_err_flags", 32'(err_flags), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_aref_cnt",  32'(aref_cnt),  32'd0);
    chk("rst_mode_reg",  32'(mode_reg),  32'd0);

    // Hand-computed vectors
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].cmd, tbl[i].ba, tbl[i].addr);
      chk($sformatf("tbl%0d_done", i),  32'(init_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_open", i),  32'(bank_open), 32'(tbl[i].open));
      chk($sformatf("tbl%0d_flags", i), 32'(err_flags), 32'(tbl[i].flags));
      chk($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].pulse));
    end

    // Clean init, then ACTIVE/READ one cycle apart violates tRCD
    do_reset();
    init_seq(13'h032);
    nop(2);
    step(1'b0, ACT, 2'd1, 13'h000);
    step(1'b0, RD,  2'd1, 13'h000);
    chk("rcd_flag",  32'(err_flags[5]), 32'd1);
    chk("rcd_pulse", 32'(err_pulse), 32'd1);
    chk("rcd_open",  32'(bank_open), 32'b0010);
    nop(1);
    chk("rcd_pulse_once", 32'(err_pulse), 32'd0);

    // Auto-precharge closes bank 2; re-ACTIVE is legal
    do_reset();
    init_seq(13'h021);
    nop(2);
    step(1'b0, ACT, 2'd2, 13'h000);
    nop(1);
    step(1'b0, RD, 2'd2, 13'h400);
    chk("ap_open", 32'(bank_open[2]), 32'd0);
    step(1'b0, ACT, 2'd2, 13'h000);
    chk("ap_reopen", 32'(bank_open[2]), 32'd1);
    chk("ap_flags", 32'(err_flags), 32'd0);
    chk("ap_pulse", 32'(err_pulse), 32'd0);

    // ACTIVE too soon after AUTO_REFRESH
    do_reset();
    init_seq(13'h032);
    nop(2);
    step(1'b0, AREF, 2'd0, 13'h000);
    nop(2);
    step(1'b0, ACT, 2'd3, 13'h000);
    chk("rfc_flag", 32'(err_flags[0]), 32'd1);
    chk("rfc_open", 32'(bank_open[3]), 32'd1);

    // Refresh overdue: flag appears REF_MAX cycles after READY entry
    do_reset();
    init_seq(13'h032);
    nop(REF_MAX - 1);
    chk("ref_early", 32'(err_flags[2]), 32'd0);
    nop(1);
    chk("ref_flag",  32'(err_flags[2]), 32'd1);
    chk("ref_pulse", 32'(err_pulse), 32'd1);
    step(1'b0, AREF, 2'd0, 13'h000);
    chk("ref_hold",     32'(err_flags[2]), 32'd1);
    chk("ref_no_pulse", 32'(err_pulse), 32'd0);

    // Reset mid-init, then a full restart
    do_reset();
    step(1'b0, PRE, 2'd0, 13'h400);
    nop(7);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, AREF, 2'd0, 13'h000);
      nop(7);
    end
    step(1'b1, LMR, 2'd0, 13'h1FF);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_aref", 32'(aref_cnt),  32'd0);
    chk("mid_rst_mode", 32'(mode_reg),  32'd0);
    chk("mid_rst_flags", 32'(err_flags), 32'd0);
    chk("mid_rst_open", 32'(bank_open), 32'd0);
    chk("mid_rst_pulse", 32'(err_pulse), 32'd0);
    init_seq(13'h032);

    // Random traffic checked against the model every cycle
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      if (blk % 2 == 0) init_seq(13'($urandom));
      for (int i = 0; i < 300; i++) rand_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sdram_cmd_monitor.md
SDRAM_CMD_MONITOR -- requirements
Module: sdram_cmd_monitor

Interface
REQ-001 Parameter T_RP, default 2: minimum cycles from PRECHARGE to the next non-NOP command.
REQ-002 Parameter T_RFC, default 7: minimum cycles from AUTO_REFRESH to the next non-NOP command.
REQ-003 Parameter T_MRD, default 3: minimum cycles from LOAD_MODE to the next non-NOP command.
REQ-004 Parameter T_RCD, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-005 Parameter INIT_AREF, default 8: number of AUTO_REFRESH commands required during init.
REQ-006 Parameter REF_MAX, default 750: maximum cycles allowed between consecutive AUTO_REFRESH commands after init.
REQ-007 Port sys_clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-008 Port sys_rst, input, 1: reset, synchronous and active-high.
REQ-009 Port sdram_cmd, input, 4: {cs_n,ras_n,cas_n,we_n} as driven onto the SDRAM pins.
REQ-010 Port sdram_ba, input, 2: bank address.
REQ-011 Port sdram_addr, input, 13: address bus.
REQ-012 Port init_done, output, 1: device initialisation sequence accepted.
REQ-013 Port mode_reg, output, 13: last LOAD_MODE value taken from sdram_addr.
REQ-014 Port bank_open, output, 4: one bit per bank; set means a row is open.
REQ-015 Port aref_cnt, output, 16: count of AUTO_REFRESH commands since reset, saturating at 16'hFFFF.
REQ-016 Port err_flags, output, 6: sticky error bits [0] timing, [1] init order, [2] refresh overdue, [3] ACTIVE to open bank, [4] READ/WRITE to closed bank, [5] tRCD.
REQ-017 Port err_pulse, output, 1: high for exactly one cycle in the cycle after any new error is detected.

Function
REQ-018 Decode: cs_n=1 is DESELECT and is treated as NOP; 0111 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE (sdram_addr[10]=1 means all banks); 0001 AUTO_REFRESH; 0000 LOAD_MODE; 0110 BURST_STOP.
REQ-019 All outputs are registered; each reflects the command sampled on the previous edge (latency 1).
REQ-020 Init FSM states: S_WAIT_PRE, S_WAIT_AREF, S_WAIT_MRS, S_READY.
  - S_WAIT_PRE -> S_WAIT_AREF on PRECHARGE with addr[10]=1.
  - S_WAIT_AREF -> S_WAIT_MRS after the INIT_AREF-th AUTO_REFRESH.
  - S_WAIT_MRS -> S_READY on LOAD_MODE.
REQ-021 Any non-NOP command in a pre-READY state other than the one that state expects sets err_flags[1]; the FSM holds its state.
REQ-022 init_done = 1 exactly while the FSM is in S_READY; S_READY exits only on reset.
REQ-023 A single gap counter reloads on every non-NOP command with the required guard (T_RP, T_RFC, T_MRD, else 0). Any non-NOP command issued while the counter is nonzero sets err_flags[0], and the command is still processed.
REQ-024 Bank tracking:
  - ACTIVE sets bank_open[ba]; ACTIVE to an already open bank sets err_flags[3].
  - PRECHARGE clears bank_open[ba], or all four bits if addr[10]=1.
  - READ/WRITE to a closed bank sets err_flags[4].
  - READ/WRITE with addr[10]=1 (auto-precharge) clears bank_open[ba] in the following cycle.
REQ-025 Per-bank tRCD counters load T_RCD on ACTIVE; READ/WRITE to a bank whose counter is nonzero sets err_flags[5].
REQ-026 Refresh interval counter:
  - Active only in S_READY; cleared by AUTO_REFRESH.
  - Upon reaching REF_MAX it sets err_flags[2] once and holds until the next AUTO_REFRESH.
REQ-027 AUTO_REFRESH while any bank_open bit is set sets err_flags[0].
REQ-028 Several errors in the same cycle set all corresponding bits and produce one err_pulse.
REQ-029 err_pulse fires only on a 0->1 transition of at least one err_flags bit; re-detecting an already set error produces no pulse.

Reset
REQ-030 On sys_rst=1 at a clock edge, the following clear to 0 regardless of any in-flight command: FSM (to S_WAIT_PRE), all counters, mode_reg, bank_open, aref_cnt, err_flags, err_pulse, init_done.
REQ-031 The command sampled on the same edge as reset is ignored.

Structure
REQ-032 Package sdram_pkg holds the 4-bit command encodings, init FSM state encodings, and default timing constants; all SDRAM blocks share it.
REQ-033 Sub-module sdram_bank_tracker holds one bank's open bit and tRCD counter; it is instantiated four times.

Verification
REQ-034 Correct sequence PRECHARGE-all, 8 AREF spaced 8 cycles apart, LOAD_MODE addr=13'h032 -> init_done=1 one cycle after LOAD_MODE, mode_reg=13'h032, err_flags=0.
REQ-035 ACTIVE bank 1, then READ bank 1 on the next cycle -> err_flags[5]=1 and err_pulse high for one cycle.
REQ-036 READY, no AREF for 750 cycles -> err_flags[2]=1 at cycle 751; a subsequent AREF produces no new pulse and the flag stays set.
REQ-037 AREF followed by ACTIVE 3 cycles later -> err_flags[0]=1 and bank_open[ba]=1.
REQ-038 READ with addr[10]=1 to open bank 2 -> bank_open[2]=0 on the next cycle; a following ACTIVE bank 2 raises no error.
REQ-039 sys_rst asserted mid-init (after 4 AREF) -> all outputs 0; a full sequence restarted afterwards reaches init_done.
